// File: rtl/shift_pipelined_pkg.sv
// Shared definitions for the pipelined barrel shifter: shift mode encodings
// and the layer-count helper.
package shift_pipelined_pkg;

    localparam int SHIFT_SHRU  = 0;
    localparam int SHIFT_SHRSI = 1;
    localparam int SHIFT_SHLI  = 2;

    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            bits++;
        end
        return bits;
    endfunction

endpackage

// File: rtl/join_type.sv
// N-way token join: the output fires only when every input is valid, and an
// input is accepted only together with all the others.
module join_type #(
    parameter int SIZE = 2
) (
    input  logic [SIZE-1:0] ins_valid,
    output logic [SIZE-1:0] ins_ready,
    output logic            out_valid,
    input  logic            out_ready
);

    always_comb begin
        out_valid = &ins_valid;
        ins_ready = '0;
        // Input i is ready when the consumer is ready and all *other* inputs are valid.
        for (int i = 0; i < SIZE; i++) begin
            ins_ready[i] = out_ready & (&(ins_valid | (SIZE'(1) << i)));
        end
    end

endmodule

// File: rtl/shift_pipelined_stage.sv
// One pipeline stage of the log shifter: applies layers FIRST_LAYER ..
// FIRST_LAYER+NUM_LAYERS-1 and either registers the token or passes it through.
module shift_stage
    import shift_pipelined_pkg::*;
#(
    parameter int DATA_TYPE   = 32,
    parameter int SHIFT_MODE  = SHIFT_SHRU,
    parameter int AMT_W       = 5,
    parameter int FIRST_LAYER = 0,
    parameter int NUM_LAYERS  = 1,
    parameter int REGISTERED  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_TYPE-1:0] in_data,
    input  logic [AMT_W-1:0]     in_amt,
    input  logic                 in_over,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_TYPE-1:0] out_data,
    output logic [AMT_W-1:0]     out_amt,
    output logic                 out_over
);

    logic [DATA_TYPE-1:0] shifted;

    always_comb begin
        shifted = in_data;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (in_amt[FIRST_LAYER + k]) begin
                case (SHIFT_MODE)
                    SHIFT_SHRSI: shifted = $signed(shifted) >>> (1 << (FIRST_LAYER + k));
                    SHIFT_SHLI:  shifted = shifted << (1 << (FIRST_LAYER + k));
                    default:     shifted = shifted >> (1 << (FIRST_LAYER + k));
                endcase
            end
        end
    end

    generate
        if (REGISTERED != 0) begin : g_reg
            logic                 valid_q;
            logic [DATA_TYPE-1:0] data_q;
            logic [AMT_W-1:0]     amt_q;
            logic                 over_q;

            // Load when empty or when the held token leaves this cycle.
            assign in_ready = ~valid_q | out_ready;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                    amt_q   <= '0;
                    over_q  <= 1'b0;
                end else if (in_ready) begin
                    valid_q <= in_valid;
                    if (in_valid) begin
                        data_q <= shifted;
                        amt_q  <= in_amt;
                        over_q <= in_over;
                    end
                end
            end

            assign out_valid = valid_q;
            assign out_data  = data_q;
            assign out_amt   = amt_q;
            assign out_over  = over_q;
        end else begin : g_comb
            assign in_ready  = out_ready;
            assign out_valid = in_valid;
            assign out_data  = shifted;
            assign out_amt   = in_amt;
            assign out_over  = in_over;
        end
    endgenerate

endmodule

// File: rtl/shift_pipelined.sv
// Elastic barrel shifter: joins lhs/rhs tokens and shifts lhs by rhs through
// NUM_STAGES registered stages with valid/ready back-pressure.
module shift_pipelined
    import shift_pipelined_pkg::*;
#(
    parameter int DATA_TYPE  = 32,
    parameter int SHIFT_MODE = SHIFT_SHRU,
    parameter int NUM_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_TYPE-1:0] lhs,
    input  logic                 lhs_valid,
    output logic                 lhs_ready,
    input  logic [DATA_TYPE-1:0] rhs,
    input  logic                 rhs_valid,
    output logic                 rhs_ready,
    output logic [DATA_TYPE-1:0] result,
    output logic                 result_valid,
    input  logic                 result_ready
);

    // Valid/ready: a token moves across a boundary on a clock edge where both
    // valid and ready are high; valid never depends on ready of the same boundary.
    localparam int LAYERS = clog2(DATA_TYPE);
    localparam int NS     = (NUM_STAGES == 0) ? 1 : NUM_STAGES;
    localparam int BASE   = LAYERS / NS;
    localparam int REM    = LAYERS % NS;
    localparam logic [DATA_TYPE-1:0] WIDTH_VAL = DATA_TYPE'(DATA_TYPE);

    logic                 stage_valid [0:NS];
    logic                 stage_ready [0:NS];
    logic [DATA_TYPE-1:0] stage_data  [0:NS];
    logic [LAYERS-1:0]    stage_amt   [0:NS];
    logic                 stage_over  [0:NS];
    logic [1:0]           join_ready;

    join_type #(.SIZE(2)) u_join (
        .ins_valid ({rhs_valid, lhs_valid}),
        .ins_ready (join_ready),
        .out_valid (stage_valid[0]),
        .out_ready (stage_ready[0])
    );

    assign lhs_ready     = join_ready[0];
    assign rhs_ready     = join_ready[1];
    assign stage_data[0] = lhs;
    assign stage_amt[0]  = rhs[LAYERS-1:0];
    // Over-shift is judged on the full rhs width, never on the truncated amount.
    assign stage_over[0] = (rhs >= WIDTH_VAL);

    generate
        for (genvar i = 0; i < NS; i++) begin : g_stage
            shift_stage #(
                .DATA_TYPE   (DATA_TYPE),
                .SHIFT_MODE  (SHIFT_MODE),
                .AMT_W       (LAYERS),
                .FIRST_LAYER (i * BASE + ((i < REM) ? i : REM)),
                .NUM_LAYERS  (BASE + ((i < REM) ? 1 : 0)),
                .REGISTERED  ((NUM_STAGES == 0) ? 0 : 1)
            ) u_stage (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (stage_valid[i]),
                .in_ready  (stage_ready[i]),
                .in_data   (stage_data[i]),
                .in_amt    (stage_amt[i]),
                .in_over   (stage_over[i]),
                .out_valid (stage_valid[i+1]),
                .out_ready (stage_ready[i+1]),
                .out_data  (stage_data[i+1]),
                .out_amt   (stage_amt[i+1]),
                .out_over  (stage_over[i+1])
            );
        end
    endgenerate

    assign stage_ready[NS] = result_ready;
    assign result_valid    = stage_valid[NS];

    // Arithmetic shifts keep the sign in the MSB, so it is the over-shift fill.
    always_comb begin
        result = stage_data[NS];
        if (stage_over[NS]) begin
            if (SHIFT_MODE == SHIFT_SHRSI) begin
                result = {DATA_TYPE{stage_data[NS][DATA_TYPE-1]}};
            end else begin
                result = '0;
            end
        end
    end

endmodule

// File: tb/tb_shift_pipelined.sv
// Randomized bench for shift_pipelined: three instances (one per shift mode)
// share the input stream; a scoreboard checks every result in order.
module tb_shift_pipelined;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] lhs;
    logic [W-1:0] rhs;
    logic         lhs_valid;
    logic         rhs_valid;
    logic         result_ready;
    logic         rand_ready_en;

    logic [W-1:0] res       [3];
    logic         res_valid [3];
    logic         l_rdy     [3];
    logic         r_rdy     [3];

    logic [W-1:0] exp_q [3][$];
    logic [W-1:0] held  [3];
    logic         prev_stall;
    int           n_tests;
    int           n_fail;
    int           n_pop;

    always #5 clk = ~clk;

    shift_pipelined #(.DATA_TYPE(W), .SHIFT_MODE(0), .NUM_STAGES(2)) dut_shru (
        .clk(clk), .rst(rst), .lhs(lhs), .lhs_valid(lhs_valid), .lhs_ready(l_rdy[0]),
        .rhs(rhs), .rhs_valid(rhs_valid), .rhs_ready(r_rdy[0]),
        .result(res[0]), .result_valid(res_valid[0]), .result_ready(result_ready)
    );
    shift_pipelined #(.DATA_TYPE(W), .SHIFT_MODE(1), .NUM_STAGES(2)) dut_shrsi (
        .clk(clk), .rst(rst), .lhs(lhs), .lhs_valid(lhs_valid), .lhs_ready(l_rdy[1]),
        .rhs(rhs), .rhs_valid(rhs_valid), .rhs_ready(r_rdy[1]),
        .result(res[1]), .result_valid(res_valid[1]), .result_ready(result_ready)
    );
    shift_pipelined #(.DATA_TYPE(W), .SHIFT_MODE(2), .NUM_STAGES(2)) dut_shli (
        .clk(clk), .rst(rst), .lhs(lhs), .lhs_valid(lhs_valid), .lhs_ready(l_rdy[2]),
        .rhs(rhs), .rhs_valid(rhs_valid), .rhs_ready(r_rdy[2]),
        .result(res[2]), .result_valid(res_valid[2]), .result_ready(result_ready)
    );

    // Reference: plain SV shifts already give 0 / sign fill for amounts >= W.
    function automatic logic [W-1:0] model(input int mode, input logic [W-1:0] l, input logic [W-1:0] r);
        case (mode)
            0:       return l >> r;
            1:       return W'($signed(l) >>> r);
            default: return l << r;
        endcase
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard / monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && res_valid[0]) begin
                for (int i = 0; i < 3; i++) check("stall_hold", res[i], held[i]);
            end
            if (lhs_valid && rhs_valid && l_rdy[0]) begin
                check("join_symmetric", W'(r_rdy[0]), W'(l_rdy[0]));
                for (int i = 0; i < 3; i++) exp_q[i].push_back(model(i, lhs, rhs));
            end
            if (res_valid[0] && result_ready) begin
                n_pop++;
                for (int i = 0; i < 3; i++) begin
                    check("valid_agree", W'(res_valid[i]), W'(res_valid[0]));
                    if (exp_q[i].size() == 0) begin
                        check("unexpected_token", W'(1), W'(0));
                    end else begin
                        check("result", res[i], exp_q[i].pop_front());
                    end
                end
            end
            prev_stall = res_valid[0] && !result_ready;
            for (int i = 0; i < 3; i++) held[i] = res[i];
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready_en) result_ready = ($urandom_range(0, 99) < 30);
    end

    // Driver: called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send(input logic [W-1:0] l, input logic [W-1:0] r, output int tries);
        logic acc;
        lhs = l;
        rhs = r;
        lhs_valid = 1'b1;
        rhs_valid = 1'b1;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 100) begin
            @(negedge clk);
            acc = l_rdy[0];
            tries++;
            @(posedge clk);
            #1;
        end
        check("send_accepted", W'(acc), W'(1));
        lhs_valid = 1'b0;
        rhs_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q[0].size() != 0) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", W'(exp_q[0].size()), W'(0));
    endtask

    task automatic directed(input string tag, input logic [W-1:0] l, input logic [W-1:0] r,
                            input int idx, input logic [W-1:0] exp);
        int tries;
        int n;
        send(l, r, tries);
        n = 0;
        @(negedge clk);
        while (!res_valid[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, res[idx], exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tries;
        int pops_before;
        logic [W-1:0] l;
        logic [W-1:0] r;

        n_tests = 0;
        n_fail = 0;
        n_pop = 0;
        prev_stall = 1'b0;
        rand_ready_en = 1'b0;
        rst = 1'b1;
        lhs = '0;
        rhs = '0;
        lhs_valid = 1'b0;
        rhs_valid = 1'b1;
        result_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("reset_valid", W'(res_valid[i]), W'(0));
            check("reset_result", res[i], '0);
        end
        check("reset_lhs_ready", W'(l_rdy[0]), W'(1));
        rhs_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Latency: result_valid appears exactly two cycles after the handshake cycle
        send(32'hF000_0000, 32'd4, tries);
        check("latency_c1", W'(res_valid[0]), W'(0));
        @(posedge clk);
        #1;
        check("latency_c2", W'(res_valid[0]), W'(1));
        check("shru_basic", res[0], 32'h0F00_0000);
        @(posedge clk);
        #1;
        drain();

        directed("shrsi_4", 32'h8000_0010, 32'd4, 1, 32'hF800_0001);
        directed("shrsi_40", 32'h8000_0010, 32'd40, 1, 32'hFFFF_FFFF);
        directed("shrsi_pos32", 32'h7FFF_FFFF, 32'd32, 1, 32'h0000_0000);
        directed("shli_31", 32'h0000_0001, 32'd31, 2, 32'h8000_0000);
        directed("shli_huge", 32'h0000_0001, 32'hFFFF_FFFF, 2, 32'h0000_0000);
        directed("shru_32", 32'hFFFF_FFFF, 32'd32, 0, 32'h0000_0000);
        drain();

        // Join: lhs alone never issues a token
        pops_before = n_pop;
        lhs = 32'h1234_5678;
        lhs_valid = 1'b1;
        rhs_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("join_lhs_ready", W'(l_rdy[0]), W'(0));
            check("join_no_token", W'(res_valid[0]), W'(0));
            @(posedge clk);
            #1;
        end
        send(32'h1234_5678, 32'd8, tries);
        drain();
        repeat (3) @(posedge clk);
        #1;
        check("join_one_result", W'(n_pop - pops_before), W'(1));

        // Full-rate throughput with result_ready held high
        for (int t = 0; t < 20; t++) begin
            send($urandom, W'($urandom_range(0, 31)), tries);
            check("throughput", W'(tries), W'(1));
        end
        drain();

        // Random back-pressure at roughly 30% ready duty
        rand_ready_en = 1'b1;
        for (int t = 0; t < 100; t++) begin
            repeat ($urandom_range(0, 1)) begin
                @(posedge clk);
                #1;
            end
            l = $urandom;
            r = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 33));
            send(l, r, tries);
        end
        drain();
        @(posedge clk);
        rand_ready_en = 1'b0;
        #2;
        result_ready = 1'b1;

        // Asynchronous reset with two tokens in flight
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        send(32'hAAAA_5555, 32'd3, tries);
        send(32'h8000_0000, 32'd1, tries);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("async_rst_valid", W'(res_valid[i]), W'(0));
            check("async_rst_result", res[i], '0);
            exp_q[i].delete();
        end
        #3;
        rst = 1'b0;
        result_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("no_stale_token", W'(res_valid[0]), W'(0));
        end
        @(posedge clk);
        #1;
        directed("after_reset", 32'h8000_0F00, 32'd8, 1, 32'hFF80_000F);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
